uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver. It captures each byte the receiver completes (one-cycle `rx_done_tick` strobe plus `dout`) into a circular FIFO. It presents the oldest byte to the consumer (CPU/bus interface) in first-word-fall-through fashion. It also reports level, almost-full and a sticky overflow flag, so that bytes arriving faster than software drains them are never silently lost.

## Interface

Parameters:
- `DATA_W`, 8: byte width; must match receiver `dout` width.
- `ADDR_W`, 4: pointer width; depth = 2^ADDR_W (16).
- `AF_LEVEL`, 12: `almost_full` asserts when level >= AF_LEVEL; legal range 1..2^ADDR_W.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `reset`, input, 1: asynchronous, active-low reset.
- `wr`, input, 1: push strobe; driven by receiver `rx_done_tick`.
- `w_data`, input, DATA_W: byte to push; driven by receiver `dout`; sampled only when `wr`=1.
- `rd`, input, 1: pop strobe from the consumer; one byte per cycle high.
- `r_data`, output, DATA_W: oldest stored byte; 0 when `empty`.
- `empty`, output, 1: no bytes stored.
- `full`, output, 1: level = 2^ADDR_W.
- `level`, output, ADDR_W+1: number of stored bytes, 0..2^ADDR_W.
- `almost_full`, output, 1: level >= AF_LEVEL.
- `overflow`, output, 1: sticky; a push was dropped.
- `clr_ovf`, input, 1: one-cycle clear of `overflow`.

## Operation

- Storage: 2^ADDR_W x DATA_W array, not reset. Write pointer `w_ptr` and read pointer `r_ptr` are ADDR_W bits and wrap naturally from 2^ADDR_W-1 to 0. `level` is kept as a separate counter, which removes full/empty ambiguity.
- Push accepted when `wr`=1 and (`full`=0 or `rd`=1). On accept: mem[w_ptr] <= w_data and w_ptr+1.
- Pop accepted when `rd`=1 and `empty`=0. On accept: r_ptr+1.
- Level update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Boundary rules:
  - `rd` while empty: ignored, no pointer change, no error flag.
  - `wr` while empty with `rd`=1: push accepted, pop ignored. The byte appears next cycle.
  - `wr`=`rd`=1 while full: both accepted, level stays 2^ADDR_W, `overflow` unchanged.
  - `wr`=1, `rd`=0 while full: byte dropped, pointers and level unchanged, `overflow` <= 1.
  - `clr_ovf` in the same cycle as a drop: set wins, `overflow` stays 1.
- `empty`, `full` and `almost_full` are registered flags updated alongside `level`. They are never decoded from a stale level.
- `r_data` = empty ? 0 : mem[r_ptr] (combinational read of registered state).

## Timing

- Reset (`reset`=0, asynchronous): w_ptr=r_ptr=0, level=0, empty=1, full=0, almost_full=0, overflow=0, r_data=0. Release is synchronous to the next `clk` edge. A reset during a push discards all stored data.
- Push latency: `wr` at edge N, then `empty`=0, `level`+1 and the byte on `r_data` (if it is the head) after edge N, i.e. visible in cycle N+1.
- Pop latency: `rd` at edge N consumes the byte shown on `r_data` in cycle N. The next byte (or 0 if now empty) appears in cycle N+1.
- Throughput: one push and one pop per cycle. The receiver strobe rate (>= 160 clocks per byte) is far below this.
- `overflow` sets at the edge of the dropped push. It clears at the edge where `clr_ovf`=1 and no drop occurs.

## Structure

- Shared package `uart_pkg` holds `UART_DATA_W` (8), used by the receiver, the transmitter and this block.
- Natural sub-module: `uart_fifo_ram`, a simple dual-port array with synchronous write and asynchronous read. It is reused by a future TX FIFO. Pointers, level, flags and overflow logic stay in `uart_rx_fifo`.
- Top-level hookup: `wr` <= uart_rx.rx_done_tick, `w_data` <= uart_rx.dout.

## Test plan

- Reset, then push 0x55 for one cycle. Next cycle: empty=0, level=1, r_data=0x55. Pop: next cycle empty=1, r_data=0.
- Push 0x00..0x0F (16 bytes). Expected: full=1, level=16, almost_full=1 from the 12th push. Pop all 16: data in order 0x00..0x0F, then empty=1.
- Fill to 16, then push 0xAA with rd=0. Expected: overflow=1, level=16, head still 0x00. Assert clr_ovf: overflow=0.
- Full FIFO, wr=rd=1 with 0xC3. Expected: level stays 16, overflow=0, 0xC3 read last after 15 pops.
- Empty FIFO, rd=1 for 3 cycles: no change, level=0. Drop and clr_ovf in the same cycle: overflow stays 1.
- Push 10 bytes, assert reset low mid-stream. Expected immediately: empty=1, level=0, r_data=0. After release, push 0x7E: it is read back first.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and their FIFOs.
package uart_pkg;

    localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through head,
// level counter, registered flags and a sticky overflow on dropped bytes.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              almost_full,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] AF_L  = (ADDR_W+1)'(AF_LEVEL);

    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, drop;
    logic [DATA_W-1:0] ram_rdata;

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (w_ptr_q),
        .wdata_i (w_data),
        .raddr_i (r_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        push    = wr & (~full_q | rd);
        pop     = rd & ~empty_q;
        drop    = wr & ~push;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        if (push) begin
            w_ptr_d = w_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            r_ptr_d = r_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (ADDR_W+1)'(1);
        end
        // Flags come from the next level so they stay aligned with it.
        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH);
        af_d    = (level_d >= AF_L);
        ovf_d   = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign r_data      = empty_q ? '0 : ram_rdata;
    assign empty       = empty_q;
    assign full        = full_q;
    assign level       = level_q;
    assign almost_full = af_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AFL   = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr, rd, clr_ovf;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, almost_full, overflow;
    logic [4:0] level;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ovf;

    uart_rx_fifo #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .AF_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".level"}, 32'(level), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, ".af"}, 32'(almost_full), 32'(n >= AFL));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".rdata"}, 32'(r_data), (n == 0) ? 32'h0 : 32'(mq[0]));
    endtask

    // One clock: drive, let the edge happen, update model, compare.
    task automatic step(input string tag, input bit w, input logic [7:0] d,
                        input bit r, input bit c);
        bit can_push, can_pop;
        wr      = w;
        w_data  = d;
        rd      = r;
        clr_ovf = c;
        can_push = w && (mq.size() < DEPTH || r);
        can_pop  = r && mq.size() > 0;
        @(posedge clk);
        if (can_pop) void'(mq.pop_front());
        if (can_push) mq.push_back(d);
        if (w && !can_push) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        #1;
        check_all(tag);
    endtask

    initial begin
        int mode;
        reset   = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_ovf = 1'b0;
        w_data  = 8'h00;
        m_ovf   = 1'b0;
        #12;
        check_all("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("release");

        step("push55", 1, 8'h55, 0, 0);
        step("pop55", 0, 8'h00, 1, 0);

        for (int i = 0; i < 16; i++) step("fill", 1, 8'(i), 0, 0);
        for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1, 0);

        for (int i = 0; i < 16; i++) step("fill2", 1, 8'(i), 0, 0);
        step("dropAA", 1, 8'hAA, 0, 0);
        step("clrovf", 0, 8'h00, 0, 1);
        step("fullwr", 1, 8'hC3, 1, 0);
        for (int i = 0; i < 16; i++) step("drainC3", 0, 8'h00, 1, 0);

        for (int i = 0; i < 3; i++) step("rdempty", 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) step("fill3", 1, 8'(i + 32), 0, 0);
        step("dropclr", 1, 8'h99, 0, 1);
        step("clrovf2", 0, 8'h00, 0, 1);
        step("bothempty", 0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) step("drain3", 0, 8'h00, 1, 0);
        step("wrrdempty", 1, 8'h3C, 1, 0);

        for (int i = 0; i < 10; i++) step("prerst", 1, 8'(i + 64), 0, 0);
        wr     = 1'b1;
        w_data = 8'hEE;
        #2;
        reset = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        #1;
        check_all("asyncrst");
        wr = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("postrst");
        step("push7E", 1, 8'h7E, 0, 0);
        step("pop7E", 0, 8'h00, 1, 0);

        for (int i = 0; i < 600; i++) begin
            bit w, r, c;
            mode = (i / 50) % 3;
            case (mode)
                0: begin
                    w = ($urandom_range(99) < 75);
                    r = ($urandom_range(99) < 20);
                end
                1: begin
                    w = ($urandom_range(99) < 20);
                    r = ($urandom_range(99) < 75);
                end
                default: begin
                    w = ($urandom_range(99) < 50);
                    r = ($urandom_range(99) < 50);
                end
            endcase
            c = ($urandom_range(99) < 5);
            step("rand", w, 8'($urandom), r, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
